// File: rtl/cr_xp10_decomp_lz77_hb_mp.sv
// cr_xp10_decomp_lz77_hb_mp: XP10 LZ77 history buffer with prefix slots, 2-cycle reads, bypass and user append pointer.
// Optional per-word even parity is enabled by defining CR_XP10_LZ77_HB_PARITY_EN.
module cr_xp10_decomp_lz77_hb_mp #(
  parameter int DW = 128,
  parameter int HB_DEPTH = 4096,
  parameter int PFX_DEPTH = 64,
  parameter int NUM_PFX = 3,
  localparam int AW = $clog2(HB_DEPTH),
  localparam int PW = $clog2(PFX_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ag_hb_wr,
  input  logic [AW-1:0]         ag_hb_waddr,
  input  logic [DW-1:0]         ag_hb_wdata,
  input  logic                  ag_hb_rd,
  input  logic [AW-1:0]         ag_hb_raddr,
  output logic [DW-1:0]         hb_ag_rdata,
  output logic                  hb_ag_rvalid,
  input  logic                  ag_hb_eof,
  input  logic [NUM_PFX-1:0]    pl_pfx_wr,
  input  logic [NUM_PFX*PW-1:0] pl_pfx_waddr,
  input  logic [NUM_PFX*DW-1:0] pl_pfx_wdata,
  input  logic [NUM_PFX-1:0]    pl_pfx_in_use,
  input  logic                  pl_hb_usr_wr,
  input  logic [DW-1:0]         pl_hb_usr_wdata,
  output logic                  hb_pl_usr_stall,
  output logic [AW-1:0]         hb_pl_usr_waddr,
  output logic [NUM_PFX-1:0]    hb_pfx_wr_drop,
  output logic                  hb_ecc_err,
  output logic [NUM_PFX-1:0]    pfx_ecc_err
);
  localparam int SW = NUM_PFX > 1 ? $clog2(NUM_PFX) : 1;
`ifdef CR_XP10_LZ77_HB_PARITY_EN
  localparam int MW = DW + 1;
  function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
    return {^d, d};
  endfunction
`else
  localparam int MW = DW;
  function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
    return d;
  endfunction
`endif

  logic [MW-1:0] hist_mem [HB_DEPTH];
  logic [MW-1:0] pfx_mem  [NUM_PFX][PFX_DEPTH];
  logic [MW-1:0] hist_q;
  logic [MW-1:0] pfx_q [NUM_PFX];

  logic [SW-1:0] sel;
  logic          any_use, w_hit, r_hit, usr_acc;
  logic [AW-1:0] usr_ptr, ptr_nxt;
  logic          hist_we, hist_we_q;
  logic [AW-1:0] hist_wa, hist_wa_q;
  logic [DW-1:0] hist_wd, hist_wd_q;
  logic [NUM_PFX-1:0] ag_pfx, pfx_we, pfx_we_q;
  logic [PW-1:0] pfx_wa [NUM_PFX];
  logic [PW-1:0] pfx_wa_q [NUM_PFX];
  logic [DW-1:0] pfx_wd [NUM_PFX];
  logic [DW-1:0] pfx_wd_q [NUM_PFX];
  logic [PW-1:0] ra_p;
  logic          byp_now, byp_prev;
  logic [DW-1:0] byp_d;
  logic          s1_vld, s1_hit, s1_byp;
  logic [SW-1:0] s1_sel;
  logic [DW-1:0] s1_bd;
  logic [MW-1:0] rd_word;

  assign any_use = |pl_pfx_in_use;
  assign w_hit = any_use & (ag_hb_waddr < AW'(PFX_DEPTH));
  assign r_hit = any_use & (ag_hb_raddr < AW'(PFX_DEPTH));
  assign ra_p = ag_hb_raddr[PW-1:0];
  assign usr_acc = pl_hb_usr_wr & ~ag_hb_wr;
  assign hb_pl_usr_stall = pl_hb_usr_wr & ag_hb_wr;
  assign hb_pl_usr_waddr = usr_ptr;
  assign hist_we = (ag_hb_wr & ~w_hit) | usr_acc;
  assign hist_wa = ag_hb_wr ? ag_hb_waddr : usr_ptr;
  assign hist_wd = ag_hb_wr ? ag_hb_wdata : pl_hb_usr_wdata;
  assign ptr_nxt = ag_hb_eof ? AW'(PFX_DEPTH) :
                   !usr_acc ? usr_ptr :
                   usr_ptr == AW'(HB_DEPTH - 1) ? AW'(PFX_DEPTH) : usr_ptr + 1'b1;

  // Lowest active slot owns prefix-range AG traffic
  always_comb begin
    sel = '0;
    for (int k = NUM_PFX - 1; k >= 0; k--)
      if (pl_pfx_in_use[k]) sel = SW'(k);
  end

  always_comb begin
    ag_pfx = '0;
    pfx_we = '0;
    for (int k = 0; k < NUM_PFX; k++) begin
      ag_pfx[k] = ag_hb_wr & w_hit & (sel == SW'(k));
      pfx_we[k] = ag_pfx[k] | pl_pfx_wr[k];
      pfx_wa[k] = ag_pfx[k] ? ag_hb_waddr[PW-1:0] : pl_pfx_waddr[k*PW +: PW];
      pfx_wd[k] = ag_pfx[k] ? ag_hb_wdata : pl_pfx_wdata[k*DW +: DW];
    end
  end

  // Same-cycle write wins over last-cycle write
  assign byp_now = r_hit ? pfx_we[sel] & (pfx_wa[sel] == ra_p) : hist_we & (hist_wa == ag_hb_raddr);
  assign byp_prev = r_hit ? pfx_we_q[sel] & (pfx_wa_q[sel] == ra_p) : hist_we_q & (hist_wa_q == ag_hb_raddr);
  assign byp_d = byp_now ? (r_hit ? pfx_wd[sel] : hist_wd) : (r_hit ? pfx_wd_q[sel] : hist_wd_q);
  assign rd_word = s1_hit ? pfx_q[s1_sel] : hist_q;

  always_ff @(posedge clk) begin
    if (hist_we) hist_mem[hist_wa] <= enc(hist_wd);
    if (ag_hb_rd & ~r_hit) hist_q <= hist_mem[ag_hb_raddr];
    hist_wa_q <= hist_wa;
    hist_wd_q <= hist_wd;
    for (int k = 0; k < NUM_PFX; k++) begin
      if (pfx_we[k]) pfx_mem[k][pfx_wa[k]] <= enc(pfx_wd[k]);
      if (ag_hb_rd & r_hit & (sel == SW'(k))) pfx_q[k] <= pfx_mem[k][ra_p];
      pfx_wa_q[k] <= pfx_wa[k];
      pfx_wd_q[k] <= pfx_wd[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usr_ptr <= AW'(PFX_DEPTH);
      hist_we_q <= 1'b0;
      pfx_we_q <= '0;
      hb_pfx_wr_drop <= '0;
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_sel <= '0;
      s1_byp <= 1'b0;
      s1_bd <= '0;
      hb_ag_rvalid <= 1'b0;
      hb_ag_rdata <= '0;
    end else begin
      usr_ptr <= ptr_nxt;
      hist_we_q <= hist_we;
      pfx_we_q <= pfx_we;
      hb_pfx_wr_drop <= pl_pfx_wr & ag_pfx;
      s1_vld <= ag_hb_rd;
      s1_hit <= r_hit;
      s1_sel <= sel;
      s1_byp <= ag_hb_rd & (byp_now | byp_prev);
      s1_bd <= byp_d;
      hb_ag_rvalid <= s1_vld;
      if (s1_vld) hb_ag_rdata <= s1_byp ? s1_bd : rd_word[DW-1:0];
    end
  end

`ifdef CR_XP10_LZ77_HB_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_ecc_err <= 1'b0;
      pfx_ecc_err <= '0;
    end else begin
      hb_ecc_err <= s1_vld & ~s1_byp & ~s1_hit & (^hist_q);
      for (int k = 0; k < NUM_PFX; k++)
        pfx_ecc_err[k] <= s1_vld & ~s1_byp & s1_hit & (s1_sel == SW'(k)) & (^pfx_q[k]);
    end
  end
`else
  assign hb_ecc_err = 1'b0;
  assign pfx_ecc_err = '0;
`endif
endmodule

// File: tb/tb_cr_xp10_decomp_lz77_hb_mp.sv
// tb_cr_xp10_decomp_lz77_hb_mp: directed self-checking bench for the XP10 LZ77 history buffer.
module tb_cr_xp10_decomp_lz77_hb_mp;
  localparam int DW = 128, AW = 12, PW = 6, NP = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic ag_hb_wr, ag_hb_rd, ag_hb_eof, pl_hb_usr_wr;
  logic [AW-1:0] ag_hb_waddr, ag_hb_raddr;
  logic [DW-1:0] ag_hb_wdata, pl_hb_usr_wdata, hb_ag_rdata;
  logic hb_ag_rvalid, hb_pl_usr_stall, hb_ecc_err;
  logic [NP-1:0] pl_pfx_wr, pl_pfx_in_use, hb_pfx_wr_drop, pfx_ecc_err;
  logic [NP*PW-1:0] pl_pfx_waddr;
  logic [NP*DW-1:0] pl_pfx_wdata;
  logic [AW-1:0] hb_pl_usr_waddr;
  int total = 0, bad = 0;

  cr_xp10_decomp_lz77_hb_mp dut (
    .clk(clk), .rst_n(rst_n),
    .ag_hb_wr(ag_hb_wr), .ag_hb_waddr(ag_hb_waddr), .ag_hb_wdata(ag_hb_wdata),
    .ag_hb_rd(ag_hb_rd), .ag_hb_raddr(ag_hb_raddr),
    .hb_ag_rdata(hb_ag_rdata), .hb_ag_rvalid(hb_ag_rvalid), .ag_hb_eof(ag_hb_eof),
    .pl_pfx_wr(pl_pfx_wr), .pl_pfx_waddr(pl_pfx_waddr), .pl_pfx_wdata(pl_pfx_wdata),
    .pl_pfx_in_use(pl_pfx_in_use), .pl_hb_usr_wr(pl_hb_usr_wr), .pl_hb_usr_wdata(pl_hb_usr_wdata),
    .hb_pl_usr_stall(hb_pl_usr_stall), .hb_pl_usr_waddr(hb_pl_usr_waddr),
    .hb_pfx_wr_drop(hb_pfx_wr_drop), .hb_ecc_err(hb_ecc_err), .pfx_ecc_err(pfx_ecc_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single read from an idle pipeline: nothing valid at T+1, data at T+2
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    ag_hb_rd = 1'b1;
    ag_hb_raddr = a;
    tick;
    ag_hb_rd = 1'b0;
    chk({tag, "_t1_vld"}, DW'(hb_ag_rvalid), '0);
    tick;
    chk({tag, "_vld"}, DW'(hb_ag_rvalid), DW'(1));
    chk(tag, hb_ag_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    {ag_hb_wr, ag_hb_rd, ag_hb_eof, pl_hb_usr_wr} = '0;
    ag_hb_waddr = '0; ag_hb_raddr = '0; ag_hb_wdata = '0; pl_hb_usr_wdata = '0;
    pl_pfx_wr = '0; pl_pfx_in_use = '0; pl_pfx_waddr = '0; pl_pfx_wdata = '0;
    tick;
    tick;
    chk("rst_rvalid", DW'(hb_ag_rvalid), '0);
    chk("rst_rdata", hb_ag_rdata, '0);
    chk("rst_ptr", DW'(hb_pl_usr_waddr), DW'(64));
    chk("rst_drop", DW'(hb_pfx_wr_drop), '0);
    chk("rst_err", DW'({hb_ecc_err, pfx_ecc_err}), '0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 5; i++) begin
      pl_hb_usr_wr = 1'b1;
      pl_hb_usr_wdata = DW'(8'hA0 + i);
      #1 chk("usr_nostall", DW'(hb_pl_usr_stall), '0);
      tick;
    end
    pl_hb_usr_wr = 1'b0;
    chk("ptr_69", DW'(hb_pl_usr_waddr), DW'(69));
    for (int i = 0; i < 7; i++) begin
      ag_hb_rd = i < 5;
      ag_hb_raddr = AW'(64 + i);
      tick;
      if (i == 0) chk("pipe_vld0", DW'(hb_ag_rvalid), '0);
      else if (i < 6) begin
        chk("pipe_vld", DW'(hb_ag_rvalid), DW'(1));
        chk("pipe_data", hb_ag_rdata, DW'(8'hA0 + i - 1));
      end else begin
        chk("pipe_vld_end", DW'(hb_ag_rvalid), '0);
        chk("pipe_hold", hb_ag_rdata, DW'(8'hA4));
      end
    end

    ag_hb_wr = 1'b1; ag_hb_waddr = 5; ag_hb_wdata = 'h0505;
    tick;
    pl_pfx_in_use = 3'b110;
    ag_hb_wdata = 'h55;
    tick;
    ag_hb_wr = 1'b0;
    tick;
    rd_chk("pfx_slot1", 5, 'h55);
    pl_pfx_in_use = 3'b000;
    rd_chk("hist5_kept", 5, 'h0505);

    ag_hb_wr = 1'b1; ag_hb_waddr = 200; ag_hb_wdata = 'hCC;
    pl_hb_usr_wr = 1'b1; pl_hb_usr_wdata = 'hB0;
    #1 chk("stall_on", DW'(hb_pl_usr_stall), DW'(1));
    tick;
    chk("stall_ptr", DW'(hb_pl_usr_waddr), DW'(69));
    ag_hb_wr = 1'b0;
    #1 chk("stall_off", DW'(hb_pl_usr_stall), '0);
    tick;
    pl_hb_usr_wr = 1'b0;
    chk("ptr_70", DW'(hb_pl_usr_waddr), DW'(70));
    rd_chk("stall_data", 69, 'hB0);
    rd_chk("ag_200", 200, 'hCC);

    ag_hb_wr = 1'b1; ag_hb_waddr = 100; ag_hb_wdata = 'h77;
    tick;
    ag_hb_wr = 1'b0;
    tick;
    ag_hb_wr = 1'b1; ag_hb_wdata = 'h1;
    ag_hb_rd = 1'b1; ag_hb_raddr = 100;
    tick;
    ag_hb_wr = 1'b0;
    tick;
    chk("byp_t_vld", DW'(hb_ag_rvalid), DW'(1));
    chk("byp_t", hb_ag_rdata, 'h1);
    ag_hb_rd = 1'b0;
    tick;
    chk("byp_t1_vld", DW'(hb_ag_rvalid), DW'(1));
    chk("byp_t1", hb_ag_rdata, 'h1);
    rd_chk("byp_ram", 100, 'h1);

    pl_hb_usr_wr = 1'b1; pl_hb_usr_wdata = 'hE0; ag_hb_eof = 1'b1;
    tick;
    pl_hb_usr_wr = 1'b0; ag_hb_eof = 1'b0;
    chk("eof_ptr", DW'(hb_pl_usr_waddr), DW'(64));
    rd_chk("eof_data", 70, 'hE0);
    for (int i = 64; i < 4095; i++) begin
      pl_hb_usr_wr = 1'b1;
      pl_hb_usr_wdata = DW'(i);
      tick;
    end
    chk("ptr_4095", DW'(hb_pl_usr_waddr), DW'(4095));
    pl_hb_usr_wdata = 'hF0;
    tick;
    pl_hb_usr_wr = 1'b0;
    chk("wrap_ptr", DW'(hb_pl_usr_waddr), DW'(64));
    rd_chk("wrap_data", 4095, 'hF0);
    rd_chk("fill_data", 4094, DW'(4094));

    pl_pfx_in_use = 3'b001;
    pl_pfx_wr = 3'b001; pl_pfx_waddr = 18'd3; pl_pfx_wdata = '0; pl_pfx_wdata[DW-1:0] = 'hD0D;
    ag_hb_wr = 1'b1; ag_hb_waddr = 3; ag_hb_wdata = 'hAA;
    tick;
    pl_pfx_wr = '0; ag_hb_wr = 1'b0;
    chk("drop_pulse", DW'(hb_pfx_wr_drop), DW'(1));
    tick;
    chk("drop_clear", DW'(hb_pfx_wr_drop), '0);
    rd_chk("drop_ag_wins", 3, 'hAA);
    pl_pfx_wr = 3'b001; pl_pfx_waddr = 18'd4; pl_pfx_wdata[DW-1:0] = 'h44;
    tick;
    pl_pfx_wr = '0;
    chk("pl_nodrop", DW'(hb_pfx_wr_drop), '0);
    tick;
    rd_chk("pl_write", 4, 'h44);

`ifdef CR_XP10_LZ77_HB_PARITY_EN
    dut.pfx_mem[0][4][0] = ~dut.pfx_mem[0][4][0];
    ag_hb_rd = 1'b1; ag_hb_raddr = 4;
    tick;
    ag_hb_rd = 1'b0;
    tick;
    chk("par_vld", DW'(hb_ag_rvalid), DW'(1));
    chk("par_pfx_err", DW'(pfx_ecc_err), DW'(1));
    chk("par_hb_err", DW'(hb_ecc_err), '0);
    tick;
    chk("par_pulse_end", DW'(pfx_ecc_err), '0);
`else
    chk("noparity_err", DW'({hb_ecc_err, pfx_ecc_err}), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
